// File: rtl/ext_bus_register_bank.sv
// ext_bus_register_bank
//   A bank of NUM_REGS registers, each DATA_W bits wide, that sits on the slave side of the
//   Avalon-to-external-bus bridge. It supports byte-lane writes and WAIT_STATES extra cycles
//   before acknowledge.
//
//   Out-of-range addresses are still acknowledged, so the bus never hangs:
//     - reads of an out-of-range address return 0;
//     - writes to an out-of-range address are dropped.
//
//   Optional feature, enabled by defining EXT_BUS_WR_LOCK_EN:
//     - register NUM_REGS-1 becomes a lock mask;
//     - while bit i of the mask is 1, writes to register i are acknowledged but discarded.
//
// Ports:
//   clk_clk        rising-edge clock
//   reset_reset    synchronous, active-high reset
//   address        bridge byte address (ADDR_W)
//   bus_enable     request, held by the bridge until it sees acknowledge
//   byte_enable    per-lane write enables (DATA_W/8)
//   rw             1 = read, 0 = write
//   write_data     write data (DATA_W)
//   acknowledge    one-cycle completion pulse
//   read_data      read result; valid in the acknowledge cycle, held until the next one
//   registers_flat register i at bits [i*DATA_W +: DATA_W]
//   write_strobe   one-cycle pulse, aligned with acknowledge, for the register that was written
module ext_bus_register_bank #(
  parameter int                WAIT_STATES = 1,
  parameter int                DATA_W      = 16,
  parameter int                NUM_REGS    = 8,
  parameter int                ADDR_W      = 19,
  parameter logic [DATA_W-1:0] REG_RESET   = '0
) (
  input  logic                         clk_clk,
  input  logic                         reset_reset,
  input  logic [ADDR_W-1:0]            address,
  input  logic                         bus_enable,
  input  logic [DATA_W/8-1:0]          byte_enable,
  input  logic                         rw,
  input  logic [DATA_W-1:0]            write_data,
  output logic                         acknowledge,
  output logic [DATA_W-1:0]            read_data,
  output logic [NUM_REGS*DATA_W-1:0]   registers_flat,
  output logic [NUM_REGS-1:0]          write_strobe
);

  localparam int LANES = DATA_W / 8;
  localparam int LSB   = $clog2(LANES);
  localparam int IDX   = $clog2(NUM_REGS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]        state, state_nxt;
  logic [3:0]        wait_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [LANES-1:0]  be_q;
  logic              rw_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] read_data_q;
  logic [DATA_W-1:0] regs [NUM_REGS];

  logic [IDX-1:0]    idx;
  logic              in_range;
  logic              locked;
  logic              wr_fire;
  logic [DATA_W-1:0] rd_sel;

  // Decoding works from the captured address, so the bridge may change its inputs
  // after the request has been taken.
  assign idx      = addr_q[LSB +: IDX];
  assign in_range = (addr_q >> (LSB + IDX)) == '0;

`ifdef EXT_BUS_WR_LOCK_EN
  logic [DATA_W-1:0] lock_mask;
  assign lock_mask = regs[NUM_REGS-1];
  // The lock register itself is always writable.
  assign locked    = (idx != IDX'(NUM_REGS - 1)) && lock_mask[idx];
`else
  assign locked    = 1'b0;
`endif

  // A write with no lanes enabled has no effect and produces no strobe.
  assign wr_fire     = (state == S_ACK) && !rw_q && in_range && (|be_q) && !locked;
  assign rd_sel      = in_range ? regs[idx] : '0;
  assign acknowledge = (state == S_ACK);
  assign read_data   = (state == S_ACK && rw_q) ? rd_sel : read_data_q;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    write_strobe = '0;
    if (wr_fire) write_strobe[idx] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (bus_enable) state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_ACK;
      // The counter is loaded with WAIT_STATES (at least 1 here), so reaching 1
      // means this is the last wait cycle.
      S_WAIT: if (wait_cnt == 4'd1) state_nxt = S_ACK;
      S_ACK:  state_nxt = S_HOLD;
      S_HOLD: if (!bus_enable) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values whatever order the blocks run in.
    if (reset_reset) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      addr_q      <= '0;
      be_q        <= '0;
      rw_q        <= 1'b0;
      wdata_q     <= '0;
      read_data_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && bus_enable) begin
        addr_q   <= address;
        be_q     <= byte_enable;
        rw_q     <= rw;
        wdata_q  <= write_data;
        wait_cnt <= 4'(WAIT_STATES);
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (state == S_ACK && rw_q) read_data_q <= rd_sel;
    end
  end

  always_ff @(posedge clk_clk) begin
    // NOTE: the register array is reset on purpose. Every register has a defined
    // power-on value that consumers see, so this array is not treated as an
    // uninitialised RAM.
    if (reset_reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= REG_RESET;
    end else if (wr_fire) begin
      for (int b = 0; b < LANES; b++)
        if (be_q[b]) regs[idx][8*b +: 8] <= wdata_q[8*b +: 8];
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign registers_flat[g*DATA_W +: DATA_W] = regs[g];
  end

endmodule

// File: tb/tb_ext_bus_register_bank.sv
// Directed bench for ext_bus_register_bank.
//   Three instances are used:
//     - dut:    default build, WAIT_STATES = 1
//     - dut_w0: WAIT_STATES = 0
//     - dut_w15: WAIT_STATES = 15
//   Expected register contents are tracked by hand in exp_flat.
module tb_ext_bus_register_bank;

  localparam int DW = 16;
  localparam int NR = 8;
  localparam int AW = 19;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] address;
  logic          bus_enable, be_w0, be_w15;
  logic [1:0]    byte_enable;
  logic          rw;
  logic [DW-1:0] write_data;

  logic             ack, ack_w0, ack_w15;
  logic [DW-1:0]    rdata, rdata_w0, rdata_w15;
  logic [NR*DW-1:0] flat, flat_w0, flat_w15;
  logic [NR-1:0]    strobe, strobe_w0, strobe_w15;

  ext_bus_register_bank dut (
    .clk_clk(clk), .reset_reset(rst), .address(address), .bus_enable(bus_enable),
    .byte_enable(byte_enable), .rw(rw), .write_data(write_data), .acknowledge(ack),
    .read_data(rdata), .registers_flat(flat), .write_strobe(strobe));

  ext_bus_register_bank #(.WAIT_STATES(0)) dut_w0 (
    .clk_clk(clk), .reset_reset(rst), .address(address), .bus_enable(be_w0),
    .byte_enable(byte_enable), .rw(rw), .write_data(write_data), .acknowledge(ack_w0),
    .read_data(rdata_w0), .registers_flat(flat_w0), .write_strobe(strobe_w0));

  ext_bus_register_bank #(.WAIT_STATES(15)) dut_w15 (
    .clk_clk(clk), .reset_reset(rst), .address(address), .bus_enable(be_w15),
    .byte_enable(byte_enable), .rw(rw), .write_data(write_data), .acknowledge(ack_w15),
    .read_data(rdata_w15), .registers_flat(flat_w15), .write_strobe(strobe_w15));

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one transaction on the default instance.
  //   lat: cycles from the sampling edge to the acknowledge, or -1 on timeout.
  //   After the first edge the live inputs are scrambled, so a design that does not
  //   use its captured copies gives visibly wrong results.
  task automatic xact(input logic [AW-1:0] a, input logic [1:0] be, input logic r,
                      input logic [DW-1:0] d, output int lat,
                      output logic [NR-1:0] stb, output logic [DW-1:0] rd);
    @(negedge clk);
    address = a; byte_enable = be; rw = r; write_data = d; bus_enable = 1'b1;
    lat = -1; stb = '0; rd = '0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (ack) begin
        lat = c; stb = strobe; rd = rdata;
        break;
      end
      if (c == 1) begin
        address = a ^ 19'h2; byte_enable = ~be; rw = ~r; write_data = ~d;
      end
    end
    @(negedge clk); bus_enable = 1'b0;
    @(negedge clk);
  endtask

  logic [127:0]  exp_flat;
  int            lat, n_ack;
  logic [NR-1:0] stb;
  logic [DW-1:0] rd;

  initial begin
    rst = 1'b1; bus_enable = 1'b0; be_w0 = 1'b0; be_w15 = 1'b0;
    address = '0; byte_enable = '0; rw = 1'b0; write_data = '0;
    exp_flat = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ack",    ack,    0);
    check("reset_rdata",  rdata,  0);
    check("reset_strobe", strobe, 0);
    check("reset_flat",   flat,   exp_flat);
    @(negedge clk); rst = 1'b0;

    // Full-lane write of 0xBEEF to register 3.
    xact(19'h6, 2'b11, 1'b0, 16'hBEEF, lat, stb, rd);
    exp_flat[63:48] = 16'hBEEF;
    check("wr_beef_lat",    lat,  2);
    check("wr_beef_strobe", stb,  8'h08);
    check("wr_beef_flat",   flat, exp_flat);

    // Low-lane-only write updates just the low byte.
    xact(19'h6, 2'b01, 1'b0, 16'h1234, lat, stb, rd);
    exp_flat[63:48] = 16'hBE34;
    check("wr_lane0_strobe", stb,  8'h08);
    check("wr_lane0_flat",   flat, exp_flat);

    xact(19'h6, 2'b00, 1'b1, 16'h0000, lat, stb, rd);
    check("rd_r3_lat",    lat, 2);
    check("rd_r3_data",   rd,  16'hBE34);
    check("rd_r3_strobe", stb, 8'h00);

    // The byte-offset address bit is ignored, so 0x7 still selects register 3.
    xact(19'h7, 2'b10, 1'b0, 16'hAB00, lat, stb, rd);
    exp_flat[63:48] = 16'hAB34;
    check("wr_off_strobe", stb,  8'h08);
    check("wr_off_flat",   flat, exp_flat);

    // Out-of-range read and write.
    xact(19'h10, 2'b11, 1'b1, 16'h0000, lat, stb, rd);
    check("rd_oor_lat",  lat, 2);
    check("rd_oor_data", rd,  16'h0000);
    xact(19'h10, 2'b11, 1'b0, 16'hFFFF, lat, stb, rd);
    check("wr_oor_lat",    lat,  2);
    check("wr_oor_strobe", stb,  8'h00);
    check("wr_oor_flat",   flat, exp_flat);

    // A write with no lanes enabled is acknowledged with no effect.
    xact(19'h2, 2'b00, 1'b0, 16'hFFFF, lat, stb, rd);
    check("wr_be0_lat",    lat,  2);
    check("wr_be0_strobe", stb,  8'h00);
    check("wr_be0_flat",   flat, exp_flat);

    // WAIT_STATES = 0: bus_enable is held for 5 cycles past acknowledge.
    @(negedge clk);
    address = 19'h6; rw = 1'b1; byte_enable = 2'b11; be_w0 = 1'b1;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (ack_w0) begin lat = c; break; end
    end
    check("w0_lat", lat, 1);
    n_ack = 0;
    repeat (5) begin @(posedge clk); #1; if (ack_w0) n_ack++; end
    check("w0_no_second_ack", n_ack, 0);
    @(negedge clk); be_w0 = 1'b0;

    // WAIT_STATES = 15.
    @(negedge clk); be_w15 = 1'b1;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (ack_w15) begin lat = c; break; end
    end
    check("w15_lat", lat, 16);
    n_ack = 0;
    repeat (5) begin @(posedge clk); #1; if (ack_w15) n_ack++; end
    check("w15_no_second_ack", n_ack, 0);
    @(negedge clk); be_w15 = 1'b0;
    @(negedge clk);

    // Reset during the wait state of a write of 0xAAAA to register 2.
    @(negedge clk);
    address = 19'h4; rw = 1'b0; byte_enable = 2'b11; write_data = 16'hAAAA; bus_enable = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_wait_ack", ack, 0);
    @(negedge clk); rst = 1'b1; bus_enable = 1'b0;
    @(posedge clk); #1;
    n_ack = ack ? 1 : 0;
    @(negedge clk); rst = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (ack) n_ack++; end
    check("rst_mid_no_ack", n_ack, 0);
    exp_flat = '0;
    check("rst_mid_flat", flat, exp_flat);
    xact(19'h4, 2'b11, 1'b0, 16'h1111, lat, stb, rd);
    exp_flat[47:32] = 16'h1111;
    check("post_rst_lat",    lat,  2);
    check("post_rst_strobe", stb,  8'h04);
    check("post_rst_flat",   flat, exp_flat);

    // Lock mask in register 7 (plain storage in the default build).
    xact(19'hE, 2'b11, 1'b0, 16'h0004, lat, stb, rd);
    exp_flat[127:112] = 16'h0004;
    check("lock_set_strobe", stb,  8'h80);
    check("lock_set_flat",   flat, exp_flat);
    xact(19'h4, 2'b11, 1'b0, 16'h5555, lat, stb, rd);
    check("locked_wr_lat", lat, 2);
`ifdef EXT_BUS_WR_LOCK_EN
    check("locked_wr_strobe", stb, 8'h00);
`else
    exp_flat[47:32] = 16'h5555;
    check("locked_wr_strobe", stb, 8'h04);
`endif
    check("locked_wr_flat", flat, exp_flat);
    xact(19'hE, 2'b11, 1'b0, 16'h0000, lat, stb, rd);
    exp_flat[127:112] = 16'h0000;
    check("lock_clr_strobe", stb,  8'h80);
    xact(19'h4, 2'b11, 1'b0, 16'h5555, lat, stb, rd);
    exp_flat[47:32] = 16'h5555;
    check("unlocked_wr_strobe", stb,  8'h04);
    check("unlocked_wr_flat",   flat, exp_flat);

    // bus_enable drops before acknowledge: the read still completes.
    @(negedge clk);
    address = 19'h4; rw = 1'b1; byte_enable = 2'b11; bus_enable = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); bus_enable = 1'b0;
    lat = -1;
    for (int c = 2; c <= 40; c++) begin
      @(posedge clk); #1;
      if (ack) begin lat = c; rd = rdata; break; end
    end
    check("drop_early_lat",  lat, 2);
    check("drop_early_data", rd,  16'h5555);
    @(posedge clk); #1;
    check("drop_early_hold_ack",   ack,   0);
    check("drop_early_rdata_held", rdata, 16'h5555);
    @(negedge clk);
    xact(19'h2, 2'b11, 1'b1, 16'h0000, lat, stb, rd);
    check("after_drop_lat",  lat, 2);
    check("after_drop_data", rd,  16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=completion");
    $fatal(1, "bench did not complete");
  end

endmodule

// File: doc/ext_bus_register_bank.md
Name: ext_bus_register_bank

Overview:
- Parametrised successor to the four-register external-bus peripheral.
- Provides NUM_REGS registers of DATA_W bits with byte-lane writes and a configurable number of acknowledge wait states.
- Responds safely to out-of-range addresses.
- Sits on the Avalon-to-external-bus bridge slave side; its flat register outputs feed display and other consumers.

Parameters:
DATA_W, 16, register/bus data width; multiple of 8, range 8..32
NUM_REGS, 8, number of registers; power of 2, range 2..64
ADDR_W, 19, bridge byte-address width
WAIT_STATES, 1, extra cycles before acknowledge; range 0..15
REG_RESET, 0, reset value loaded into every register

Ports:
clk_clk  input  1  single clock; all logic rising-edge
reset_reset  input  1  synchronous, active-high reset
address  input  ADDR_W  byte address from bridge
bus_enable  input  1  transaction request; held high by bridge until acknowledge seen
byte_enable  input  DATA_W/8  per-byte write lane enables
rw  input  1  1 = read, 0 = write
write_data  input  DATA_W  write data
acknowledge  output  1  one-cycle completion pulse
read_data  output  DATA_W  read result
registers_flat  output  NUM_REGS*DATA_W  register i at bits [i*DATA_W +: DATA_W]
write_strobe  output  NUM_REGS  one-cycle pulse per register on an accepted write

Behaviour:
- Reset (clk_clk edge with reset_reset=1):
  - state IDLE; acknowledge=0; read_data=0; write_strobe=0.
  - All registers = REG_RESET; wait counter = 0.
- Decode:
  - LSB = log2(DATA_W/8); IDX = log2(NUM_REGS).
  - Index = address[LSB +: IDX].
  - In range only when address[ADDR_W-1 : LSB+IDX] == 0 (byte-offset bits ignored).
- FSM states: IDLE, WAIT, ACK, HOLD.
  - IDLE: on bus_enable=1, capture address, byte_enable, rw and write_data; load counter=WAIT_STATES. Go to WAIT if WAIT_STATES>0, else ACK.
  - WAIT: decrement counter; go to ACK in the cycle the counter reaches 0.
  - ACK:
    - acknowledge=1 for exactly this cycle.
    - Write: lanes with byte_enable=1 update; result visible on registers_flat next cycle; write_strobe[index]=1 in the same cycle as acknowledge.
    - Read: read_data = selected register, valid in the ACK cycle and held until the next ACK.
    - Go to HOLD.
  - HOLD: stay while bus_enable=1; go to IDLE when bus_enable=0. A new request requires at least one cycle with bus_enable low.
- Latency: acknowledge rises WAIT_STATES+1 cycles after the cycle in which IDLE sampled bus_enable=1.
- Out-of-range access: acknowledge is still generated (no bus hang); reads return 0; writes are ignored; no write_strobe.
- Write with byte_enable all zero: acknowledge generated; no register change; no strobe.
- bus_enable drops before acknowledge: the captured transaction completes and acknowledge still pulses; HOLD then exits on the next cycle.
- Captured inputs are used throughout, so input changes after capture have no effect.
- Reset mid-transaction: any pending write is dropped, no acknowledge is issued, and the FSM returns to IDLE.

Optional Feature:
- Macro EXT_BUS_WR_LOCK_EN.
- Defined:
  - Register NUM_REGS-1 is a lock mask; requires DATA_W >= NUM_REGS-1.
  - While lock bit i = 1, writes to register i (i < NUM_REGS-1) are acknowledged but discarded, with no write_strobe.
  - The lock register itself is always writable.
  - Reads are unaffected.
- Not defined: all NUM_REGS registers are plain storage and no write is discarded for locking.

Test Plan:
- Defaults; write 0xBEEF to byte address 0x6 (register 3), byte_enable=2'b11 -> acknowledge exactly 2 cycles after request; write_strobe[3] pulses with acknowledge; registers_flat[63:48]=0xBEEF next cycle.
- Register 3 holds 0xBEEF; write 0x1234 with byte_enable=2'b01 -> register 3 = 0xBE34; read it back -> read_data=0xBE34 in the ACK cycle.
- Read address 0x10 (out of range) -> acknowledge after 2 cycles, read_data=0; write 0xFFFF to 0x10 -> all registers unchanged, no strobe.
- WAIT_STATES=0 and WAIT_STATES=15 -> acknowledge at +1 and +16 cycles respectively; bus_enable held 5 cycles past acknowledge -> no second acknowledge.
- Assert reset_reset during WAIT of a write of 0xAAAA to register 2 -> no acknowledge; register 2 = REG_RESET; next request served normally.
- EXT_BUS_WR_LOCK_EN: write 0x0004 to register 7, then 0x5555 to register 2 -> acknowledged, register 2 unchanged, no strobe; clear the lock and repeat -> register 2 = 0x5555.
